// File: rtl/return_stack.sv
// return_stack: hardware LIFO of subroutine return addresses.
//
// A CALL pushes push_addr, a RET pops the newest entry onto the registered
// ret_addr output. Each instruction raises aux_push_pop for two cycles, and
// only its rising edge starts a stack operation, so each instruction acts once.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   reset         synchronous, active-high; clears count, ret_addr and flags
//   push / pop    decoder levels for CALL / RET
//   aux_push_pop  two-cycle stage strobe from the control unit
//   push_addr     return address stored on a push
//   ret_addr      address produced by the most recent pop (0 on underflow)
//   count         number of valid entries (0..DEPTH)
//   empty / full  combinational decodes of count
//   overflow      sticky: push attempted while full
//   underflow     sticky: pop attempted while empty
//   conflict      sticky: push and pop both high at an operation strobe
module return_stack #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned COUNT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   aux_push_pop,
  input  logic [ADDR_WIDTH-1:0]  push_addr,
  output logic [ADDR_WIDTH-1:0]  ret_addr,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   conflict
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  logic                  aux_q;
  logic                  op_en;
  logic                  do_push;
  logic                  do_pop;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;

  assign empty = (count == '0);
  assign full  = (count == COUNT_WIDTH'(DEPTH));

  // Slot indices: count is below DEPTH whenever a write happens, and count-1
  // wraps correctly in IDX_W bits when the stack is full.
  assign wr_idx = count[IDX_W-1:0];
  assign rd_idx = wr_idx - 1'b1;

  assign op_en   = aux_push_pop & ~aux_q;
  assign do_push = op_en &  push & ~pop & ~full;
  assign do_pop  = op_en & ~push &  pop & ~empty;

  // aux_q keeps tracking the strobe through reset so that a strobe which was
  // already high when reset arrived is not seen as a fresh rising edge once
  // reset drops; with the strobe low during reset it still clears to 0.
  always_ff @(posedge clk) begin
    aux_q <= aux_push_pop;
  end

  // Entry storage has no reset; entries beyond count are don't-care.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[wr_idx] <= push_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      ret_addr  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      conflict  <= 1'b0;
    end else if (op_en) begin
      if (push && pop) begin
        conflict <= 1'b1;
      end else if (push) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end else if (pop) begin
        if (empty) begin
          ret_addr  <= '0;
          underflow <= 1'b1;
        end else begin
          ret_addr <= mem[rd_idx];
          count    <= count - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_return_stack.sv
module tb_return_stack;

  localparam int unsigned AW = 32;
  localparam int unsigned DP = 16;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic          pop;
  logic          aux_push_pop;
  logic [AW-1:0] push_addr;
  logic [AW-1:0] ret_addr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;
  logic          conflict;

  return_stack #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DP),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .aux_push_pop(aux_push_pop),
    .push_addr   (push_addr),
    .ret_addr    (ret_addr),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .underflow   (underflow),
    .conflict    (conflict)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string         name;
    int unsigned   at;
    int unsigned   cnt;
    logic [AW-1:0] ret;
    logic          ov;
    logic          un;
    logic          cf;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Monitor: compares the oldest expectation once its observation cycle arrives.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      tests += 6;
      if (count !== CW'(e.cnt)) begin
        fails++;
        $display("FAIL %s count: got %0d expected %0d", e.name, count, e.cnt);
      end
      if (ret_addr !== e.ret) begin
        fails++;
        $display("FAIL %s ret_addr: got %h expected %h", e.name, ret_addr, e.ret);
      end
      if (empty !== (e.cnt == 0)) begin
        fails++;
        $display("FAIL %s empty: got %b expected %b", e.name, empty, e.cnt == 0);
      end
      if (full !== (e.cnt == DP)) begin
        fails++;
        $display("FAIL %s full: got %b expected %b", e.name, full, e.cnt == DP);
      end
      if (overflow !== e.ov || underflow !== e.un) begin
        fails++;
        $display("FAIL %s ovf/unf: got %b%b expected %b%b", e.name,
                 overflow, underflow, e.ov, e.un);
      end
      if (conflict !== e.cf) begin
        fails++;
        $display("FAIL %s conflict: got %b expected %b", e.name, conflict, e.cf);
      end
    end
  end

  task automatic expect_at(input string nm, input int unsigned at, input int unsigned c,
                           input logic [AW-1:0] r, input logic ov, input logic un,
                           input logic cf);
    exp_t e;
    e.name = nm; e.at = at; e.cnt = c; e.ret = r; e.ov = ov; e.un = un; e.cf = cf;
    exp_q.push_back(e);
  endtask

  // One instruction: strobe held two cycles; state checked after the second
  // edge, which also proves the held strobe did not act twice.
  task automatic do_op(input logic p, input logic q, input logic [AW-1:0] a,
                       input string nm, input int unsigned c, input logic [AW-1:0] r,
                       input logic ov, input logic un, input logic cf);
    @(posedge clk); #1;
    push = p; pop = q; push_addr = a; aux_push_pop = 1'b1;
    expect_at(nm, cyc + 2, c, r, ov, un, cf);
    @(posedge clk); #1;
    @(posedge clk); #1;
    aux_push_pop = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; aux_push_pop = 1'b0; push_addr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    expect_at("reset", cyc, 0, '0, 0, 0, 0);

    // single call/return
    do_op(1, 0, 32'h10, "call1", 1, '0, 0, 0, 0);
    do_op(0, 1, '0, "ret1", 0, 32'h10, 0, 0, 0);

    // nesting
    do_op(1, 0, 32'h10, "nest_push0", 1, 32'h10, 0, 0, 0);
    do_op(1, 0, 32'h20, "nest_push1", 2, 32'h10, 0, 0, 0);
    do_op(1, 0, 32'h30, "nest_push2", 3, 32'h10, 0, 0, 0);
    do_op(0, 1, '0, "nest_pop0", 2, 32'h30, 0, 0, 0);
    do_op(0, 1, '0, "nest_pop1", 1, 32'h20, 0, 0, 0);
    do_op(0, 1, '0, "nest_pop2", 0, 32'h10, 0, 0, 0);

    // fill, overflow, drain
    for (int i = 0; i < 16; i++)
      do_op(1, 0, 32'h100 + i, $sformatf("fill%0d", i), i + 1, 32'h10, 0, 0, 0);
    do_op(1, 0, 32'hDEAD, "overflow", 16, 32'h10, 1, 0, 0);
    for (int j = 0; j < 16; j++)
      do_op(0, 1, '0, $sformatf("drain%0d", j), 15 - j, 32'h10F - j, 1, 0, 0);

    // underflow
    do_op(0, 1, '0, "underflow", 0, '0, 1, 1, 0);

    // conflict with a non-zero ret_addr that must survive
    do_op(1, 0, 32'hA1, "cf_push0", 1, '0, 1, 1, 0);
    do_op(1, 0, 32'hA2, "cf_push1", 2, '0, 1, 1, 0);
    do_op(1, 0, 32'hA3, "cf_push2", 3, '0, 1, 1, 0);
    do_op(0, 1, '0, "cf_pop", 2, 32'hA3, 1, 1, 0);
    do_op(1, 1, 32'hBEEF, "conflict", 2, 32'hA3, 1, 1, 1);

    // reset arriving together with a pop strobe
    do_op(1, 0, 32'hA4, "pre_reset", 3, 32'hA3, 1, 1, 1);
    @(posedge clk); #1;
    reset = 1'b1; pop = 1'b1; aux_push_pop = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    expect_at("reset_midop", cyc, 0, '0, 0, 0, 0);
    @(posedge clk); #1;
    expect_at("held_strobe", cyc, 0, '0, 0, 0, 0);
    aux_push_pop = 1'b0; pop = 1'b0;
    do_op(1, 0, 32'h55, "post_reset", 1, '0, 0, 0, 0);
    do_op(0, 1, '0, "post_reset_pop", 0, 32'h55, 0, 0, 0);

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    @(negedge clk); #1;
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
